// File: rtl/uivtc_pkg.sv
// Shared types for the VTC picture-in-picture mixer: FSM states, pixel-select
// codes and the RGB888 width.
package uivtc_pkg;

  localparam int RGB_W = 24;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    RUN     = 2'd1,
    DROP    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_BG     = 2'd0,
    SEL_PIP    = 2'd1,
    SEL_FILL   = 2'd2,
    SEL_BORDER = 2'd3
  } pix_sel_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? 8'hFF : val + 8'd1;
  endfunction

endpackage

// File: rtl/uivtc_pip_edge.sv
// Registered rising-edge detector: o_rise is the combinational edge,
// o_pulse the same edge delayed by one register stage.
module uivtc_pip_edge (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_sig,
  output logic o_rise,
  output logic o_pulse
);

  logic r_prev;
  logic r_pulse;

  assign o_rise  = i_sig & ~r_prev;
  assign o_pulse = r_pulse;

  // previous-value register and delayed edge pulse
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_prev  <= i_sig;
      r_pulse <= o_rise;
    end
  end

endmodule

// File: rtl/uivtc_pip_mixer.sv
// Picture-in-picture compositor behind the VTC: two-stage pipeline with FIFO
// underflow recovery. Optional window outline enabled by UIVTC_PIP_BORDER_EN.
import uivtc_pkg::*;

module uivtc_pip_mixer #(
  parameter int                PIP_W        = 640,
  parameter int                PIP_H        = 480,
  parameter logic [RGB_W-1:0]  FILL_COLOR   = 24'h000000,
  parameter logic [RGB_W-1:0]  BORDER_COLOR = 24'hFFFFFF
) (
  input  logic             I_pip_clk,
  input  logic             I_pip_rstn,
  input  logic             I_vs,
  input  logic             I_hs,
  input  logic             I_de,
  input  logic             I_pip_de,
  input  logic [RGB_W-1:0] I_bg_data,
  output logic             O_fifo_rd,
  input  logic [RGB_W-1:0] I_fifo_data,
  input  logic             I_fifo_empty,
  output logic             O_vs,
  output logic             O_hs,
  output logic             O_de,
  output logic [RGB_W-1:0] O_data,
  output logic             O_frame_start,
  output logic             O_underflow,
  output logic [7:0]       O_err_cnt
);

  state_t           r_state;
  state_t           w_state_nxt;
  state_t           w_state_run;
  pix_sel_t         w_sel;
  logic             w_rd;
  logic             w_uf;
  logic             w_vs_rise;
  logic             w_frame_start;
  logic             w_border;

  logic             r_vs1, r_hs1, r_de1;
  logic [RGB_W-1:0] r_bg1;
  pix_sel_t         r_sel1;

  logic             r_vs2, r_hs2, r_de2;
  logic [RGB_W-1:0] r_data2;
  logic             r_underflow;
  logic [7:0]       r_err_cnt;

  uivtc_pip_edge u_vs_edge (
    .i_clk   (I_pip_clk),
    .i_rstn  (I_pip_rstn),
    .i_sig   (I_vs),
    .o_rise  (w_vs_rise),
    .o_pulse (w_frame_start)
  );

`ifdef UIVTC_PIP_BORDER_EN
  localparam logic [11:0] COL_LAST = 12'(PIP_W - 1);
  localparam logic [11:0] ROW_LAST = 12'(PIP_H - 1);

  logic [11:0] r_col;
  logic [11:0] r_row;

  assign w_border = (r_col == 12'd0) || (r_col == COL_LAST) ||
                    (r_row == 12'd0) || (r_row == ROW_LAST);

  // window column/row position, restarted at every frame
  always_ff @(posedge I_pip_clk or negedge I_pip_rstn) begin
    if (!I_pip_rstn) begin
      r_col <= 12'd0;
      r_row <= 12'd0;
    end else if (w_vs_rise) begin
      r_col <= 12'd0;
      r_row <= 12'd0;
    end else if (I_pip_de) begin
      if (r_col == COL_LAST) begin
        r_col <= 12'd0;
        r_row <= (r_row == ROW_LAST) ? 12'd0 : r_row + 12'd1;
      end else begin
        r_col <= r_col + 12'd1;
      end
    end
  end
`else
  // A degenerate zero-size window is all outline; any real geometry has none.
  assign w_border = (PIP_W == 0) || (PIP_H == 0);
`endif

  // next state, FIFO pop, underflow detect and pixel-select code
  always_comb begin
    w_state_run = r_state;
    w_uf        = 1'b0;
    case (r_state)
      RUN: begin
        if (I_pip_de && I_fifo_empty) begin
          w_uf        = 1'b1;
          w_state_run = DROP;
        end else begin
          w_state_run = RUN;
        end
      end
      WAIT_VS: w_state_run = WAIT_VS;
      DROP:    w_state_run = DROP;
      default: w_state_run = WAIT_VS;
    endcase
    w_state_nxt = w_vs_rise ? RUN : w_state_run;
    w_rd        = (r_state == RUN) && I_pip_de && !I_fifo_empty;
    if (!I_pip_de) begin
      w_sel = SEL_BG;
    end else if (w_border) begin
      w_sel = SEL_BORDER;
    end else if (w_rd) begin
      w_sel = SEL_PIP;
    end else begin
      w_sel = SEL_FILL;
    end
  end

  assign O_fifo_rd = w_rd;

  // state register
  always_ff @(posedge I_pip_clk or negedge I_pip_rstn) begin
    if (!I_pip_rstn) begin
      r_state <= WAIT_VS;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // stage 1: timing, background and select code
  always_ff @(posedge I_pip_clk or negedge I_pip_rstn) begin
    if (!I_pip_rstn) begin
      r_vs1  <= 1'b0;
      r_hs1  <= 1'b0;
      r_de1  <= 1'b0;
      r_bg1  <= 24'h000000;
      r_sel1 <= SEL_BG;
    end else begin
      r_vs1  <= I_vs;
      r_hs1  <= I_hs;
      r_de1  <= I_de;
      r_bg1  <= I_bg_data;
      r_sel1 <= w_sel;
    end
  end

  // stage 2: the popped word arrives now, so the final mux lives here
  always_ff @(posedge I_pip_clk or negedge I_pip_rstn) begin
    if (!I_pip_rstn) begin
      r_vs2   <= 1'b0;
      r_hs2   <= 1'b0;
      r_de2   <= 1'b0;
      r_data2 <= 24'h000000;
    end else begin
      r_vs2 <= r_vs1;
      r_hs2 <= r_hs1;
      r_de2 <= r_de1;
      if (!r_de1) begin
        r_data2 <= 24'h000000;
      end else begin
        case (r_sel1)
          SEL_PIP:    r_data2 <= I_fifo_data;
          SEL_FILL:   r_data2 <= FILL_COLOR;
          SEL_BORDER: r_data2 <= BORDER_COLOR;
          default:    r_data2 <= r_bg1;
        endcase
      end
    end
  end

  // sticky underflow flag and saturating per-frame error count
  always_ff @(posedge I_pip_clk or negedge I_pip_rstn) begin
    if (!I_pip_rstn) begin
      r_underflow <= 1'b0;
      r_err_cnt   <= 8'd0;
    end else if (w_uf) begin
      r_underflow <= 1'b1;
      r_err_cnt   <= sat_inc8(r_err_cnt);
    end
  end

  assign O_vs          = r_vs2;
  assign O_hs          = r_hs2;
  assign O_de          = r_de2;
  assign O_data        = r_data2;
  assign O_frame_start = w_frame_start;
  assign O_underflow   = r_underflow;
  assign O_err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_uivtc_pip_mixer.sv
// Directed bench for uivtc_pip_mixer on a shrunken 8x6 frame with a 4x3 window
// at offset (2,2); honours UIVTC_PIP_BORDER_EN when defined.
`timescale 1ns/1ps
module tb_uivtc_pip_mixer;

  localparam logic [23:0] FILL = 24'h00AA55;
  localparam logic [23:0] BORD = 24'hFFFFFF;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        vs = 1'b0, hs = 1'b0, de = 1'b0, pde = 1'b0, empty = 1'b0;
  logic [23:0] bg = 24'h0;
  logic [23:0] fdata = 24'hEEEEEE;
  logic        o_rd, o_vs, o_hs, o_de, o_fs, o_uf;
  logic [23:0] o_data;
  logic [7:0]  o_err;

  int          n_assert = 0;
  int          n_fail = 0;
  int          pops = 0;
  int          cyc_cnt = 0;
  logic [23:0] src_val = 24'h100000;
  logic [23:0] seq_exp = 24'h100000;
  logic [26:0] expq[$];

  uivtc_pip_mixer #(
    .PIP_W(4), .PIP_H(3), .FILL_COLOR(FILL), .BORDER_COLOR(BORD)
  ) dut (
    .I_pip_clk(clk), .I_pip_rstn(rstn), .I_vs(vs), .I_hs(hs), .I_de(de),
    .I_pip_de(pde), .I_bg_data(bg), .O_fifo_rd(o_rd), .I_fifo_data(fdata),
    .I_fifo_empty(empty), .O_vs(o_vs), .O_hs(o_hs), .O_de(o_de),
    .O_data(o_data), .O_frame_start(o_fs), .O_underflow(o_uf), .O_err_cnt(o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // kind: 0 blank, 1 background, 2 popped FIFO word, 3 fill, 4 border
  task automatic cyc(input logic i_vs, i_hs, i_de, i_pde, i_empty,
                     input logic exp_rd, input int kind, input logic exp_fs);
    logic [23:0] ed;
    logic [23:0] popped;
    logic        rd_s;
    vs = i_vs; hs = i_hs; de = i_de; pde = i_pde; empty = i_empty;
    bg = 24'hB00000 | 24'(cyc_cnt & 16'hFFFF);
    cyc_cnt++;
    #1;
    chk("fifo_rd", {31'd0, o_rd}, {31'd0, exp_rd});
    popped = seq_exp;
    if (exp_rd) seq_exp = seq_exp + 24'd1;
    case (kind)
      0:       ed = 24'h000000;
      1:       ed = bg;
      2:       ed = popped;
      3:       ed = FILL;
      default: ed = BORD;
    endcase
    expq.push_back({i_vs, i_hs, i_de, ed});
    rd_s = o_rd;
    @(posedge clk);
    #1;
    if (rd_s) begin
      fdata = src_val;
      src_val = src_val + 24'd1;
      pops++;
    end else begin
      fdata = 24'hEEEEEE;
    end
    chk("pixel_out", {5'd0, o_vs, o_hs, o_de, o_data}, {5'd0, expq[0]});
    void'(expq.pop_front());
    chk("frame_start", {31'd0, o_fs}, {31'd0, exp_fs});
  endtask

  // one frame from first_line; uf_pix is the window pixel with empty asserted
  task automatic frame(input int first_line, input int uf_pix, input int exp_pops);
    bit reading;
    int p0;
    reading = (first_line == 0);
    p0 = pops;
    for (int y = first_line; y < 6; y++) begin
      for (int x = 0; x < 8; x++) begin
        logic v, h, d, w, e, er;
        bit   bord;
        int   pix, kind;
        v   = (y == 0) && (x < 2);
        h   = (x == 7);
        d   = (y >= 1) && (y <= 4) && (x >= 1) && (x <= 6);
        w   = (y >= 2) && (y <= 4) && (x >= 2) && (x <= 5);
        pix = (y - 2) * 4 + (x - 2);
        e   = w && (pix == uf_pix);
        er  = w && reading && !e;
        if (w && e) reading = 0;
`ifdef UIVTC_PIP_BORDER_EN
        bord = w && ((x == 2) || (x == 5) || (y == 2) || (y == 4));
`else
        bord = 0;
`endif
        if (!d)        kind = 0;
        else if (!w)   kind = 1;
        else if (bord) kind = 4;
        else if (er)   kind = 2;
        else           kind = 3;
        cyc(v, h, d, w, e, er, kind, (y == 0) && (x == 0));
      end
    end
    chk("frame_pops", 32'(pops - p0), 32'(exp_pops));
  endtask

  initial begin
    int k_ov1, k_ov2;
`ifdef UIVTC_PIP_BORDER_EN
    k_ov1 = 4; k_ov2 = 4;
`else
    k_ov1 = 3; k_ov2 = 2;
`endif
    // reset with an active window and a full FIFO: nothing may pop
    pde = 1'b1; de = 1'b1; bg = 24'h123456;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fifo_rd", {31'd0, o_rd}, 32'd0);
    chk("rst_sync", {29'd0, o_vs, o_hs, o_de}, 32'd0);
    chk("rst_data", {8'd0, o_data}, 32'd0);
    chk("rst_frame_start", {31'd0, o_fs}, 32'd0);
    chk("rst_underflow", {31'd0, o_uf}, 32'd0);
    chk("rst_err_cnt", {24'd0, o_err}, 32'd0);
    pde = 1'b0; de = 1'b0; bg = 24'h0;
    rstn = 1'b1;
    expq.push_back(27'd0);

    // mid-frame release: window shows fill and no pops until the vs edge
    frame(2, -1, 0);
    frame(0, -1, 12);
    chk("uf_clear", {31'd0, o_uf}, 32'd0);
    chk("err_zero", {24'd0, o_err}, 32'd0);

    // underflow at window pixel 5
    frame(0, 5, 5);
    chk("uf_set", {31'd0, o_uf}, 32'd1);
    chk("err_one", {24'd0, o_err}, 32'd1);
    frame(0, -1, 12);
    chk("err_hold", {24'd0, o_err}, 32'd1);
    chk("uf_sticky", {31'd0, o_uf}, 32'd1);

    // repeated underflows up to and past saturation
    for (int f = 0; f < 253; f++) frame(0, 0, 0);
    chk("err_254", {24'd0, o_err}, 32'd254);
    frame(0, 0, 0);
    chk("err_255", {24'd0, o_err}, 32'd255);
    for (int f = 0; f < 46; f++) frame(0, 0, 0);
    chk("err_sat", {24'd0, o_err}, 32'd255);

    // vs edge coinciding with an underflow: RUN wins, so the next pixel pops
    frame(0, -1, 12);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, k_ov1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, k_ov2, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    frame(0, -1, 12);
    chk("uf_final", {31'd0, o_uf}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uivtc_pip_mixer.md
# uivtc_pip_mixer

Picture-in-picture compositor that sits directly downstream of the video timing controller (VTC). It takes the VTC's registered sync/enable outputs and the full-screen background pixel, and pops second-window pixels from an upstream read FIFO whenever the PiP window enable is high. It emits a composited RGB888 stream with timing delayed to match. It detects FIFO underflow, blanks the rest of a corrupted window to a fill colour, and resynchronises on every frame start.

## Interface
Parameters:
- PIP_W, 640, PiP window width in pixels; must match the VTC's second-window width
- PIP_H, 480, PiP window height in lines
- FILL_COLOR, 24'h000000, colour substituted for PiP pixels that cannot be read
- BORDER_COLOR, 24'hFFFFFF, colour of the optional window outline

Ports:
- I_pip_clk  in  1  pixel clock, same domain as the VTC
- I_pip_rstn  in  1  asynchronous active-low reset
- I_vs  in  1  field sync from VTC, active high
- I_hs  in  1  line sync from VTC
- I_de  in  1  main active-video enable
- I_pip_de  in  1  PiP window enable from VTC; always inside I_de
- I_bg_data  in  24  background RGB888, aligned with I_de
- O_fifo_rd  out  1  FIFO pop; combinational
- I_fifo_data  in  24  FIFO read data, valid the cycle after O_fifo_rd
- I_fifo_empty  in  1  FIFO empty flag
- O_vs, O_hs, O_de  out  1 each  delayed syncs/enable
- O_data  out  24  composited pixel
- O_frame_start  out  1  one-cycle pulse on I_vs rising edge; upstream uses it to flush and restart the PiP reader
- O_underflow  out  1  sticky flag; cleared only by reset
- O_err_cnt  out  8  frames containing an underflow; saturates at 255

## Operation
- State machine states:
  - WAIT_VS: reset state. No FIFO reads. PiP pixels output FILL_COLOR.
  - RUN: PiP pixels are read from the FIFO.
  - DROP: FIFO underflowed this frame. No reads; PiP pixels output FILL_COLOR.
- Transitions:
  - Any state -> RUN on I_vs rising edge (I_vs=1, registered previous value=0). The same cycle pulses O_frame_start.
  - RUN -> DROP when I_pip_de=1 and I_fifo_empty=1 in the same cycle.
  - DROP holds until the next I_vs rising edge.
- O_fifo_rd = (state==RUN) && I_pip_de && !I_fifo_empty.
- Pixel select at stage 2:
  - PiP pixel read in RUN -> I_fifo_data.
  - PiP pixel not read -> FILL_COLOR. This covers WAIT_VS, DROP, and the underflow cycle itself.
  - Outside the window with I_de=1 -> I_bg_data.
  - I_de=0 -> 24'h0.
- Underflow cycle actions:
  - Set O_underflow.
  - Increment O_err_cnt once per frame, saturating; a second underflow in the same frame is impossible because the block is already in DROP.
- Simultaneous vs edge and underflow: the vs edge wins; the next state is RUN.
- Reset mid-frame: return to WAIT_VS. Reads are suppressed until the next frame, so a partially read FIFO is never consumed.

## Timing
- Two-stage pipeline.
  - Stage 1 registers I_vs/I_hs/I_de, I_bg_data and the pixel-select code.
  - Stage 2 combines the select code with I_fifo_data and registers all outputs.
- Latency: every output lags its input by exactly 2 cycles, so syncs, enable and data stay mutually aligned.
- O_frame_start is registered, 1 cycle after the I_vs edge.
- Reset values:
  - O_vs, O_hs, O_de, O_frame_start, O_underflow, O_fifo_rd = 0
  - O_data = 0, O_err_cnt = 0
  - state = WAIT_VS

## Configuration
- UIVTC_PIP_BORDER_EN defined:
  - The block keeps 12-bit column/row counters inside the window.
  - The column counter advances on I_pip_de and wraps at PIP_W-1, which advances the row counter; both clear on the I_vs edge.
  - Pixels with col==0, col==PIP_W-1, row==0 or row==PIP_H-1 output BORDER_COLOR.
  - The FIFO is still popped for border pixels and the data discarded, so FIFO alignment is unchanged.
  - Border pixels override FILL_COLOR.
- Not defined: the counters are absent and there is no outline; behaviour is as described in Operation.

## Structure
- Package uivtc_pkg holds:
  - the state enum (WAIT_VS, RUN, DROP)
  - the 2-bit pixel-select encoding (BG, PIP, FILL, BORDER)
  - the shared RGB888 width constant
- One sub-module, uivtc_pip_edge: a registered rising-edge detector for I_vs, reused by other VTC consumers.

## Test plan
- FIFO always non-empty, one 1024x600 frame with a 640x480 window at offset (100,50):
  - exactly 307200 pops;
  - O_data equals the FIFO sequence inside the window and I_bg_data elsewhere;
  - all outputs exactly 2 cycles late.
- Release reset mid-frame:
  - zero pops until the first I_vs edge;
  - window shows 24'h000000, then normal reading resumes the next frame.
- Assert I_fifo_empty for one cycle at window pixel 1000:
  - O_underflow sets and O_err_cnt becomes 1;
  - no further pops that frame and the remaining window shows FILL_COLOR;
  - the next frame reads normally.
- Force an underflow in 300 consecutive frames: O_err_cnt saturates at 255.
- I_vs rising edge in the same cycle as an underflow: state goes to RUN and O_frame_start pulses.
- With UIVTC_PIP_BORDER_EN:
  - the window outline equals BORDER_COLOR;
  - pop count stays 307200.
